// File: rtl/icache_dm_param.sv
// Direct-mapped, read-only instruction cache between fetch and line-based memory.
// A hit returns its word one cycle after mem_read. A miss starts a refill
// through a three-state FSM (IDLE/REFILL/RESPOND). The cache keeps saturating
// hit and miss counters. A flush during a refill discards the incoming line.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 invalidate all lines
//   mem_read, address     fetch request and byte address (bits [1:0] ignored)
//   readdata(_valid)      fetched word and its 1-cycle valid pulse
//   busy                  refill in progress, mem_read ignored
//   reqI_mem/reqAddrI_mem line request and line address to memory
//   data_from_mem, read_ready_from_mem  refill line and its 1-cycle valid pulse
//   hit_count, miss_count saturating performance counters
module icache_dm_param #(
  parameter int ADDR_W     = 32,
  parameter int LINES      = 4,
  parameter int LINE_BYTES = 16,
  parameter int CNT_W      = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 mem_read,
  input  logic [ADDR_W-1:0]                    address,
  output logic [31:0]                          readdata,
  output logic                                 readdata_valid,
  output logic                                 busy,
  output logic                                 reqI_mem,
  output logic [ADDR_W-$clog2(LINE_BYTES)-1:0] reqAddrI_mem,
  input  logic [8*LINE_BYTES-1:0]              data_from_mem,
  input  logic                                 read_ready_from_mem,
  output logic [CNT_W-1:0]                     hit_count,
  output logic [CNT_W-1:0]                     miss_count
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int LA_W   = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REFILL  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  // Select the 32-bit word addressed by a byte offset inside a line.
  function automatic logic [31:0] pick_word(input logic [LINE_W-1:0] line,
                                            input logic [OFF_W-1:0]  off);
    logic [OFF_W-1:0]  word_idx;
    logic [LINE_W-1:0] shifted;
    word_idx = off >> 2;
    shifted  = line >> {word_idx, 5'd0};
    return shifted[31:0];
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t              state_r, state_s;
  logic [LINES-1:0]    valid_r;
  logic [TAG_W-1:0]    tag_r  [LINES];
  logic [LINE_W-1:0]   data_r [LINES];
  logic [ADDR_W-1:0]   miss_addr_r;
  logic                drop_r;

  logic [31:0]         readdata_r, readdata_s;
  logic                rvalid_r, rvalid_s;
  logic                busy_r, busy_s;
  logic                req_r, req_s;
  logic [LA_W-1:0]     req_addr_r, req_addr_s;
  logic [CNT_W-1:0]    hit_cnt_r, hit_cnt_s;
  logic [CNT_W-1:0]    miss_cnt_r, miss_cnt_s;

  logic [IDX_W-1:0]    req_idx_s, miss_idx_s;
  logic [TAG_W-1:0]    req_tag_s, miss_tag_s;
  logic                hit_s, fill_s;

  assign req_idx_s  = address[IDX_W+OFF_W-1:OFF_W];
  assign req_tag_s  = address[ADDR_W-1:IDX_W+OFF_W];
  assign miss_idx_s = miss_addr_r[IDX_W+OFF_W-1:OFF_W];
  assign miss_tag_s = miss_addr_r[ADDR_W-1:IDX_W+OFF_W];
  // A flush in the same cycle forces a miss even if the line matches.
  assign hit_s  = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s) && !flush;
  // A line is installed only if no flush hit this refill and no reset is pending.
  assign fill_s = (state_r == S_REFILL) && read_ready_from_mem && !drop_r && !flush && !reset;

  assign readdata       = readdata_r;
  assign readdata_valid = rvalid_r;
  assign busy           = busy_r;
  assign reqI_mem       = req_r;
  assign reqAddrI_mem   = req_addr_r;
  assign hit_count      = hit_cnt_r;
  assign miss_count     = miss_cnt_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (mem_read && !hit_s) state_s = S_REFILL;
        else                    state_s = S_IDLE;
      end
      S_REFILL: begin
        if (read_ready_from_mem) begin
          if (drop_r || flush) state_s = S_IDLE;
          else                 state_s = S_RESPOND;
        end else begin
          state_s = S_REFILL;
        end
      end
      S_RESPOND: state_s = S_IDLE;
      default:   state_s = S_IDLE;
    endcase
  end

  // Output logic: the next value of every registered output.
  always_comb begin
    readdata_s = readdata_r;
    rvalid_s   = 1'b0;
    req_s      = req_r;
    req_addr_s = req_addr_r;
    hit_cnt_s  = hit_cnt_r;
    miss_cnt_s = miss_cnt_r;
    busy_s     = (state_s == S_REFILL);
    case (state_r)
      S_IDLE: begin
        if (mem_read) begin
          if (hit_s) begin
            readdata_s = pick_word(data_r[req_idx_s], address[OFF_W-1:0]);
            rvalid_s   = 1'b1;
            hit_cnt_s  = sat_inc(hit_cnt_r);
          end else begin
            req_s      = 1'b1;
            req_addr_s = address[ADDR_W-1:OFF_W];
            miss_cnt_s = sat_inc(miss_cnt_r);
          end
        end else begin
          req_s = 1'b0;
        end
      end
      S_REFILL: begin
        if (read_ready_from_mem) begin
          req_s = 1'b0;
          if (!drop_r && !flush) begin
            readdata_s = pick_word(data_from_mem, miss_addr_r[OFF_W-1:0]);
            rvalid_s   = 1'b1;
          end else begin
            readdata_s = readdata_r;
          end
        end else begin
          req_s = 1'b1;
        end
      end
      S_RESPOND: req_s = 1'b0;
      default:   req_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_r <= 32'd0;
      rvalid_r   <= 1'b0;
      busy_r     <= 1'b0;
      req_r      <= 1'b0;
      req_addr_r <= {LA_W{1'b0}};
      hit_cnt_r  <= {CNT_W{1'b0}};
      miss_cnt_r <= {CNT_W{1'b0}};
    end else begin
      readdata_r <= readdata_s;
      rvalid_r   <= rvalid_s;
      busy_r     <= busy_s;
      req_r      <= req_s;
      req_addr_r <= req_addr_s;
      hit_cnt_r  <= hit_cnt_s;
      miss_cnt_r <= miss_cnt_s;
    end
  end

  // Miss address capture and drop flag (set by a flush while refilling).
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_addr_r <= {ADDR_W{1'b0}};
      drop_r      <= 1'b0;
    end else begin
      if ((state_r == S_IDLE) && (state_s == S_REFILL)) miss_addr_r <= address;
      drop_r <= (state_r == S_REFILL) && (state_s == S_REFILL) && (drop_r || flush);
    end
  end

  // Valid bits; flush has priority over a refill on the same edge.
  always_ff @(posedge clk) begin
    if (reset)       valid_r <= {LINES{1'b0}};
    else if (flush)  valid_r <= {LINES{1'b0}};
    else if (fill_s) valid_r[miss_idx_s] <= 1'b1;
  end

  // Tag and data arrays; not reset.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      data_r[miss_idx_s] <= data_from_mem;
      tag_r[miss_idx_s]  <= miss_tag_s;
    end
  end

endmodule

// File: tb/tb_icache_dm_param.sv
module tb_icache_dm_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Instance A: default geometry (4 lines x 16 bytes, 32-bit counters).
  logic         reset = 1'b1, flush = 1'b0, mem_read = 1'b0, ready = 1'b0;
  logic [31:0]  address = 32'd0;
  logic [127:0] line_in = 128'd0;
  logic [31:0]  readdata;
  logic         readdata_valid, busy, reqI_mem;
  logic [27:0]  req_addr;
  logic [31:0]  hit_count, miss_count;

  icache_dm_param dut (
    .clk(clk), .reset(reset), .flush(flush), .mem_read(mem_read), .address(address),
    .readdata(readdata), .readdata_valid(readdata_valid), .busy(busy),
    .reqI_mem(reqI_mem), .reqAddrI_mem(req_addr), .data_from_mem(line_in),
    .read_ready_from_mem(ready), .hit_count(hit_count), .miss_count(miss_count)
  );

  // Instance B: 16 lines x 64 bytes, 2-bit counters to reach saturation.
  logic         b_reset = 1'b1, b_flush = 1'b0, b_mem_read = 1'b0, b_ready = 1'b0;
  logic [31:0]  b_address = 32'd0;
  logic [511:0] b_line = 512'd0;
  logic [31:0]  b_readdata;
  logic         b_valid, b_busy, b_req;
  logic [25:0]  b_req_addr;
  logic [1:0]   b_hits, b_misses;

  icache_dm_param #(.ADDR_W(32), .LINES(16), .LINE_BYTES(64), .CNT_W(2)) dut_b (
    .clk(clk), .reset(b_reset), .flush(b_flush), .mem_read(b_mem_read), .address(b_address),
    .readdata(b_readdata), .readdata_valid(b_valid), .busy(b_busy),
    .reqI_mem(b_req), .reqAddrI_mem(b_req_addr), .data_from_mem(b_line),
    .read_ready_from_mem(b_ready), .hit_count(b_hits), .miss_count(b_misses)
  );

  localparam logic [127:0] LINE_SEQ = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle fetch request on instance A.
  task automatic fetch(input logic [31:0] a);
    mem_read = 1'b1;
    address  = a;
    tick();
    mem_read = 1'b0;
  endtask

  // One-cycle ready pulse with a refill line on instance A.
  task automatic give_line(input logic [127:0] l);
    line_in = l;
    ready   = 1'b1;
    tick();
    ready   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests_run++;
    if ({readdata_valid, busy, reqI_mem} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 000", {readdata_valid, busy, reqI_mem});
    end
    tests_run++;
    if (readdata !== 32'd0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_data: rd=%h hits=%0d misses=%0d expected 0/0/0", readdata, hit_count, miss_count);
    end
  endtask

  task automatic test_miss_refill();
    fetch(32'h0000_0044);
    tests_run++;
    if (reqI_mem !== 1'b1 || req_addr !== 28'h0000004 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL miss_req: req=%b addr=%h busy=%b expected 1/0000004/1", reqI_mem, req_addr, busy);
    end
    tests_run++;
    if (miss_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL miss_cnt1: got %0d expected 1", miss_count);
    end
    tick();
    tick();
    tests_run++;
    if (reqI_mem !== 1'b1 || req_addr !== 28'h0000004 || readdata_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL refill_hold: req=%b addr=%h valid=%b expected 1/0000004/0", reqI_mem, req_addr, readdata_valid);
    end
    give_line({32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
    tests_run++;
    if (readdata_valid !== 1'b1 || readdata !== 32'hDEADBEEF || busy !== 1'b0 || reqI_mem !== 1'b0) begin
      tests_failed++;
      $display("FAIL refill_resp: valid=%b rd=%h busy=%b req=%b expected 1/deadbeef/0/0",
               readdata_valid, readdata, busy, reqI_mem);
    end
    tick();
    tests_run++;
    if (readdata_valid !== 1'b0 || readdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL rd_hold: valid=%b rd=%h expected 0/deadbeef", readdata_valid, readdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    exp_w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch(32'h0000_0040);
    tests_run++;
    if (reqI_mem !== 1'b1 || miss_count !== 32'd2) begin
      tests_failed++;
      $display("FAIL flush_miss: req=%b misses=%0d expected 1/2", reqI_mem, miss_count);
    end
    give_line(LINE_SEQ);
    tick();
    mem_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      address = 32'h40 + 32'(4 * i);
      tick();
      tests_run++;
      if (readdata_valid !== 1'b1 || readdata !== exp_w[i] || reqI_mem !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_hit%0d: valid=%b rd=%h req=%b expected 1/%h/0", i, readdata_valid, readdata, reqI_mem, exp_w[i]);
      end
    end
    mem_read = 1'b0;
    tests_run++;
    if (hit_count !== 32'd4) begin
      tests_failed++;
      $display("FAIL b2b_hits: got %0d expected 4", hit_count);
    end
  endtask

  task automatic test_conflict();
    fetch(32'h0000_0140);
    tests_run++;
    if (reqI_mem !== 1'b1 || req_addr !== 28'h0000014 || miss_count !== 32'd3) begin
      tests_failed++;
      $display("FAIL conf_miss: req=%b addr=%h misses=%0d expected 1/0000014/3", reqI_mem, req_addr, miss_count);
    end
    give_line({32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0});
    tests_run++;
    if (readdata_valid !== 1'b1 || readdata !== 32'hA0A0A0A0) begin
      tests_failed++;
      $display("FAIL conf_resp: valid=%b rd=%h expected 1/a0a0a0a0", readdata_valid, readdata);
    end
    tick();
    fetch(32'h0000_0040);
    tests_run++;
    if (reqI_mem !== 1'b1 || miss_count !== 32'd4 || readdata_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL conf_evict: req=%b misses=%0d valid=%b expected 1/4/0", reqI_mem, miss_count, readdata_valid);
    end
    give_line(LINE_SEQ);
    tick();
    fetch(32'h0000_0048);
    tests_run++;
    if (readdata_valid !== 1'b1 || readdata !== 32'h33333333 || hit_count !== 32'd5) begin
      tests_failed++;
      $display("FAIL conf_rehit: valid=%b rd=%h hits=%0d expected 1/33333333/5", readdata_valid, readdata, hit_count);
    end
  endtask

  task automatic test_flush_refill();
    int pulses;
    fetch(32'h0000_0090);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if (reqI_mem !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_hold: req=%b busy=%b expected 1/1", reqI_mem, busy);
    end
    tick();
    tick();
    pulses = 0;
    give_line({32'h93939393, 32'h92929292, 32'h91919191, 32'h90909090});
    pulses += int'(readdata_valid);
    tick();
    pulses += int'(readdata_valid);
    tests_run++;
    if (pulses != 0 || reqI_mem !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_drop: pulses=%0d req=%b busy=%b expected 0/0/0", pulses, reqI_mem, busy);
    end
    fetch(32'h0000_0094);
    tests_run++;
    if (reqI_mem !== 1'b1 || miss_count !== 32'd6) begin
      tests_failed++;
      $display("FAIL flush_refetch: req=%b misses=%0d expected 1/6", reqI_mem, miss_count);
    end
    give_line({32'h93939393, 32'h92929292, 32'h91919191, 32'h90909090});
    tests_run++;
    if (readdata_valid !== 1'b1 || readdata !== 32'h91919191) begin
      tests_failed++;
      $display("FAIL flush_resp: valid=%b rd=%h expected 1/91919191", readdata_valid, readdata);
    end
    tick();
    // flush coinciding with the ready pulse also drops the line
    fetch(32'h0000_00A0);
    flush = 1'b1;
    give_line({32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0});
    flush = 1'b0;
    tests_run++;
    if (readdata_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_same: valid=%b busy=%b expected 0/0", readdata_valid, busy);
    end
    tick();
    fetch(32'h0000_00A0);
    tests_run++;
    if (reqI_mem !== 1'b1 || miss_count !== 32'd8) begin
      tests_failed++;
      $display("FAIL flush_same_refetch: req=%b misses=%0d expected 1/8", reqI_mem, miss_count);
    end
    give_line({32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0});
    tick();
  endtask

  task automatic test_reset_mid_refill();
    fetch(32'h0000_00B0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if ({readdata_valid, busy, reqI_mem} !== 3'b000 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_mid: ctrl=%b hits=%0d misses=%0d expected 000/0/0",
               {readdata_valid, busy, reqI_mem}, hit_count, miss_count);
    end
    give_line({32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0});
    tests_run++;
    if ({readdata_valid, busy, reqI_mem} !== 3'b000 || readdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_stray: ctrl=%b rd=%h expected 000/00000000", {readdata_valid, busy, reqI_mem}, readdata);
    end
    tick();
    fetch(32'h0000_00B0);
    tests_run++;
    if (reqI_mem !== 1'b1 || readdata_valid !== 1'b0 || miss_count !== 32'd1 || hit_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_nowrite: req=%b valid=%b misses=%0d hits=%0d expected 1/0/1/0",
               reqI_mem, readdata_valid, miss_count, hit_count);
    end
    give_line({32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0});
    tick();
  endtask

  task automatic test_wide_geometry();
    logic [1:0] exp_hits [4];
    exp_hits = '{2'd1, 2'd2, 2'd3, 2'd3};
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    b_mem_read = 1'b1;
    b_address  = 32'h0000_07FC;
    tick();
    b_mem_read = 1'b0;
    tests_run++;
    if (b_req !== 1'b1 || b_req_addr !== 26'h000001F || b_misses !== 2'd1) begin
      tests_failed++;
      $display("FAIL wide_req: req=%b addr=%h misses=%0d expected 1/000001f/1", b_req, b_req_addr, b_misses);
    end
    b_line  = {32'hCAFEF00D, 448'd0, 32'h12345678};
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    tests_run++;
    if (b_valid !== 1'b1 || b_readdata !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL wide_resp: valid=%b rd=%h expected 1/cafef00d", b_valid, b_readdata);
    end
    tick();
    b_mem_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (b_valid !== 1'b1 || b_readdata !== 32'hCAFEF00D || b_hits !== exp_hits[i]) begin
        tests_failed++;
        $display("FAIL wide_sat%0d: valid=%b rd=%h hits=%0d expected 1/cafef00d/%0d",
                 i, b_valid, b_readdata, b_hits, exp_hits[i]);
      end
    end
    b_mem_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_back_to_back();
    test_conflict();
    test_flush_refill();
    test_reset_mid_refill();
    test_wide_geometry();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
